// File: rtl/sel_pipe_mux_if.sv
// Handshake bundle for sel_pipe_mux: the upstream candidate/select side and
// the downstream registered-result side travel together in one interface.
// The selector itself uses the slave view; whatever drives it uses master.
interface sel_pipe_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);

  // upstream side: a select index plus every packed candidate
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_bus;

  // downstream side: the registered selection and its range flag
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    out_err;

  // producer of candidates and consumer of results
  modport master (
    output in_valid,
    output sel,
    output in_bus,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  out_err
  );

  // the selector block
  modport slave (
    input  in_valid,
    input  sel,
    input  in_bus,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output out_err
  );

endinterface

// File: rtl/sel_pipe_mux.sv
// Registered NUM_IN-way selector with valid/ready flow control.
// The output register is backed by a single skid entry, so the block keeps
// one transfer per cycle while in_ready comes only from registered state:
// when the consumer stalls, the one transfer already in flight lands in the
// skid instead of being lost. A select beyond the last candidate yields zero
// data with out_err raised, rather than aliasing onto a real candidate.
module sel_pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic          clk,
  input  logic          reset,
  sel_pipe_mux_if.slave bus
);

  // output register contents
  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;
  logic             out_valid_q;

  // skid entry contents
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;
  logic             skid_valid_q;

  // combinational selection of the presented candidate
  logic [WIDTH-1:0] pick_data;
  logic             pick_err;

  // handshake qualifiers
  logic             ready_int;
  logic             accept;
  logic             out_free;

  // Ready depends only on the skid flag and reset, never on out_ready, so no
  // combinational path runs from the downstream consumer back upstream.
  assign ready_int = !skid_valid_q && !reset;
  assign accept    = bus.in_valid && ready_int;
  assign out_free  = !out_valid_q || bus.out_ready;

  // Decode sel against only the populated candidates; unmatched codes stay at
  // the zero/error default so they can never alias to a real input.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        pick_data = bus.in_bus[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // Output register and skid entry update: the skid always drains first to
  // keep FIFO order, and a stalled output register never changes its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_err_q    <= skid_err_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= accept;
        if (accept) begin
          skid_data_q <= pick_data;
          skid_err_q  <= pick_err;
        end
      end else begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= pick_data;
          out_err_q  <= pick_err;
        end
      end
    end else if (accept) begin
      skid_data_q  <= pick_data;
      skid_err_q   <= pick_err;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed and randomised checks of sel_pipe_mux in three configurations:
// a 4-way 32-bit selector, a 3-way 32-bit selector with one unused select
// code, and a 5-way 8-bit selector driven randomly against a scoreboard.
module tb_sel_pipe_mux;

  logic clk;
  logic reset;

  int checks;
  int errors;

  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b4 ();
  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b3 ();
  sel_pipe_mux_if #(.WIDTH(8),  .NUM_IN(5), .SEL_W(3)) b5 ();

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  sel_pipe_mux #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b5.slave)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one scoreboard entry per accepted transfer: {err, data}
  logic [8:0] sb[$];
  logic [8:0] sb_head;
  logic [8:0] exp_entry;
  logic       held_valid;
  logic [8:0] held_entry;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive the 4-way selector's handshake inputs
  task automatic applyStimulus(input logic valid, input logic [1:0] s, input logic rdy);
    b4.in_valid  = valid;
    b4.sel       = s;
    b4.out_ready = rdy;
  endtask

  // single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [31:0] cand4 [4];
    cand4[0] = 32'h1111_1111;
    cand4[1] = 32'h2222_2222;
    cand4[2] = 32'h3333_3333;
    cand4[3] = 32'h4444_4444;
    checks     = 0;
    errors     = 0;
    held_valid = 1'b0;
    held_entry = '0;

    reset        = 1'b1;
    b4.in_bus    = {cand4[3], cand4[2], cand4[1], cand4[0]};
    applyStimulus(1'b1, 2'd2, 1'b1);
    b3.in_valid  = 1'b1;
    b3.sel       = 2'd0;
    b3.in_bus    = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};
    b3.out_ready = 1'b1;
    b5.in_valid  = 1'b0;
    b5.sel       = '0;
    b5.in_bus    = '0;
    b5.out_ready = 1'b1;

    // reset held three cycles with in_valid asserted
    $display("[TB] reset phase");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_in_ready", 32'(b4.in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(b4.out_valid), 32'd0);
      checkOutput("rst_data_out", b4.data_out, 32'd0);
      checkOutput("rst_out_err", 32'(b4.out_err), 32'd0);
    end
    checkOutput("rst_u3_in_ready", 32'(b3.in_ready), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    b3.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(b4.in_ready), 32'd1);
    checkOutput("post_rst_u5_in_ready", 32'(b5.in_ready), 32'd1);

    // basic select, back-to-back with out_ready high
    $display("[TB] basic select");
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b1);
      tick();
      checkOutput($sformatf("basic_data_%0d", i), b4.data_out, cand4[i]);
      checkOutput($sformatf("basic_valid_%0d", i), 32'(b4.out_valid), 32'd1);
      checkOutput($sformatf("basic_err_%0d", i), 32'(b4.out_err), 32'd0);
      checkOutput($sformatf("basic_ready_%0d", i), 32'(b4.in_ready), 32'd1);
    end
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("basic_idle_valid", 32'(b4.out_valid), 32'd0);

    // out-of-range select on the 3-way instance, then valid neighbours
    $display("[TB] out-of-range select");
    b3.in_valid = 1'b1;
    b3.sel      = 2'd3;
    tick();
    checkOutput("oor_data", b3.data_out, 32'd0);
    checkOutput("oor_err", 32'(b3.out_err), 32'd1);
    checkOutput("oor_valid", 32'(b3.out_valid), 32'd1);
    b3.sel = 2'd1;
    tick();
    checkOutput("oor_next_data", b3.data_out, 32'hBBBB_1111);
    checkOutput("oor_next_err", 32'(b3.out_err), 32'd0);
    b3.sel = 2'd2;
    tick();
    checkOutput("oor_last_data", b3.data_out, 32'hCCCC_2222);
    checkOutput("oor_last_err", 32'(b3.out_err), 32'd0);
    b3.in_valid = 1'b0;
    tick();
    checkOutput("oor_idle_valid", 32'(b3.out_valid), 32'd0);

    // back-pressure: A=cand0, B=cand1, C=cand2, D=cand3
    $display("[TB] back-pressure");
    applyStimulus(1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("bp_A_data", b4.data_out, cand4[0]);
    applyStimulus(1'b1, 2'd1, 1'b0);
    tick();
    checkOutput("bp_skid_in_ready", 32'(b4.in_ready), 32'd0);
    checkOutput("bp_hold_A_data", b4.data_out, cand4[0]);
    checkOutput("bp_hold_A_valid", 32'(b4.out_valid), 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    tick();
    checkOutput("bp_still_in_ready", 32'(b4.in_ready), 32'd0);
    checkOutput("bp_still_A_data", b4.data_out, cand4[0]);
    applyStimulus(1'b1, 2'd2, 1'b1);
    tick();
    checkOutput("bp_B_data", b4.data_out, cand4[1]);
    checkOutput("bp_drain_in_ready", 32'(b4.in_ready), 32'd1);
    tick();
    checkOutput("bp_C_data", b4.data_out, cand4[2]);
    applyStimulus(1'b1, 2'd3, 1'b1);
    tick();
    checkOutput("bp_D_data", b4.data_out, cand4[3]);
    checkOutput("bp_D_valid", 32'(b4.out_valid), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("bp_idle_valid", 32'(b4.out_valid), 32'd0);

    // reset while stalled with a full skid
    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b0);
    tick();
    checkOutput("ms_full_in_ready", 32'(b4.in_ready), 32'd0);
    checkOutput("ms_full_valid", 32'(b4.out_valid), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("ms_rst_valid", 32'(b4.out_valid), 32'd0);
    checkOutput("ms_rst_data", b4.data_out, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("ms_skid_empty", 32'(b4.in_ready), 32'd1);
    applyStimulus(1'b1, 2'd3, 1'b1);
    tick();
    checkOutput("ms_first_data", b4.data_out, cand4[3]);
    checkOutput("ms_first_valid", 32'(b4.out_valid), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("ms_no_stale_valid", 32'(b4.out_valid), 32'd0);

    // random stress on the 5-way 8-bit instance, then a forced drain
    $display("[TB] random stress");
    for (int cyc = 0; cyc < 2010; cyc++) begin
      if (cyc < 2000) begin
        b5.in_valid  = ($urandom_range(0, 3) != 0);
        b5.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        b5.in_valid  = 1'b0;
        b5.out_ready = 1'b1;
      end
      b5.sel    = 3'($urandom_range(0, 7));
      b5.in_bus = {8'($urandom), 32'($urandom)};
      @(negedge clk);
      if (held_valid) begin
        checkOutput("stall_valid", 32'(b5.out_valid), 32'd1);
        checkOutput("stall_entry", 32'({b5.out_err, b5.data_out}), 32'(held_entry));
      end
      if (b5.out_valid && b5.out_ready) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_head = sb.pop_front();
          checkOutput("rand_entry", 32'({b5.out_err, b5.data_out}), 32'(sb_head));
        end
      end
      held_valid = b5.out_valid && !b5.out_ready;
      held_entry = {b5.out_err, b5.data_out};
      if (b5.in_valid && b5.in_ready) begin
        if (b5.sel >= 3'd5)
          exp_entry = {1'b1, 8'h00};
        else
          exp_entry = {1'b0, b5.in_bus[b5.sel*8 +: 8]};
        sb.push_back(exp_entry);
      end
      tick();
    end
    checkOutput("rand_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("rand_idle_valid", 32'(b5.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_pipe_mux.md
# sel_pipe_mux

Parametrised, registered N-input selector with a valid/ready handshake and a one-entry skid buffer, the pipelined successor of the 32-bit 2-to-1 datapath mux. It sits between pipeline stages of the MIPS datapath (e.g. ALU operand / forwarding select, writeback select). It picks one of NUM_IN WIDTH-bit candidates per transfer and registers the result. It sustains one transfer per cycle under back-pressure, and flags out-of-range selects instead of silently aliasing them.

## Interface
- WIDTH, 32, data width of every candidate and of the output
- NUM_IN, 4, number of candidate inputs (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents sel/in_bus this cycle
- in_ready  output  1  block can accept this cycle
- sel  input  SEL_W  candidate index
- in_bus  input  NUM_IN*WIDTH  packed candidates; candidate k = in_bus[k*WIDTH +: WIDTH]
- out_valid  output  1  data_out/out_err hold a transfer
- out_ready  input  1  downstream accepts this cycle
- data_out  output  WIDTH  selected candidate
- out_err  output  1  transfer had sel >= NUM_IN

## Operation
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- On accept: selected = (sel < NUM_IN) ? candidate[sel] : 0; err = (sel >= NUM_IN). sel and in_bus are sampled only on accept.
- Storage: output register (data_out, out_err, out_valid) plus one skid entry (skid_data, skid_err, skid_valid).
- in_ready = !skid_valid && !reset.
- Each clock edge, when not in reset:
  - Output register free (!out_valid || out_ready):
    - Skid full: output register loads the skid entry and the skid clears. If a new accept also occurs, it enters the skid.
    - Skid empty: output register loads the accept, or out_valid <= 0 if there is none.
  - Output register stalled (out_valid && !out_ready): an accept loads the skid; the output register holds its value unchanged.
- Order is strictly FIFO. No transfer is dropped or duplicated.
- out_valid is never withdrawn before delivery. data_out and out_err are stable while out_valid && !out_ready.
- Reset at any point, including mid-stall, discards the output register and skid contents.

## Timing
- Reset values: out_valid=0, data_out=0, out_err=0, skid_valid=0. in_ready=0 while reset is high and 1 on the first cycle after.
- Latency: an input accepted at edge n appears on data_out/out_valid after edge n (1 cycle) when the output register is free.
- Throughput: 1 transfer/cycle with out_ready held high. in_ready depends only on registered state (no combinational out_ready -> in_ready path).
- Back-pressure: after out_ready drops, at most one more transfer is absorbed (into the skid). in_ready falls in the following cycle. After out_ready returns, the skid drains in 1 cycle and in_ready rises the cycle after that.
- When deliver and accept occur in the same cycle with an empty skid, the new value replaces data_out at the edge with no bubble.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, data_out=0, out_err=0. Release reset -> in_ready=1 the next cycle.
- Basic select, NUM_IN=4, candidates {0x11111111, 0x22222222, 0x33333333, 0x44444444}, out_ready=1, sel=0,1,2,3 on consecutive cycles -> data_out 0x11111111..0x44444444 one cycle later each, out_valid continuous, out_err=0.
- Out-of-range, NUM_IN=3, SEL_W=2, sel=3 -> data_out=0, out_err=1. The next transfer with sel=1 returns candidate 1 with out_err=0.
- Back-pressure: stream values A, B, C, D with out_ready=0 from the cycle A appears -> B is absorbed into the skid and in_ready=0 while C is held upstream. Raise out_ready -> A, B, C, D delivered in order with none lost or duplicated.
- Random stress: 2000 cycles of random in_valid/out_ready/sel with WIDTH=8, NUM_IN=5, SEL_W=3, checked against a scoreboard queue -> order and values match, out_err set exactly when sel>=5, and data_out is stable whenever a stall holds it.
- Reset mid-stall: skid full and out_valid=1 with out_ready=0, then assert reset for 1 cycle -> out_valid=0 and skid empty. The first post-reset transfer is delivered correctly and no stale data is seen.
